// File: rtl/l2_lookup_sched.sv
// ---------------------------------------------------------------------------
// l2_lookup_sched
//
// Sequences the L2 tag/state lookup datapath and arbitrates it between CPU
// requests (mode L2_LOOKUP) and incoming forwards (mode L2_LOOKUP_FWD).
// One transaction walks IDLE -> RD_SET -> LOOKUP -> RESP. A forward wins
// arbitration unless a waiting request has already been passed over
// FWD_STARVE_MAX consecutive times.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/ready/tag/set/id   CPU request channel (ready is combinational)
//   fwd_valid/ready/tag/set/id   forward channel (ready is combinational)
//   rd_en, rd_set                tag/state buffer read strobe and set
//   lookup_en/mode/tag           lookup trigger, 0 = L2_LOOKUP, 1 = L2_LOOKUP_FWD
//   tag_hit_next, way_hit_next,
//   empty_way_found_next,
//   empty_way_next               combinational lookup result
//   resp_valid/ready, resp_*     captured result, held until handshake
//   busy                         FSM not in IDLE
//
// Optional feature macro: L2_LKP_PIPE_EN
//   When defined, arbitration also runs in RESP while resp_ready = 1 so a new
//   transaction starts directly in RD_SET (one transaction per 3 cycles).
// ---------------------------------------------------------------------------
module l2_lookup_sched #(
  parameter int SET_BITS       = 9,
  parameter int TAG_BITS       = 15,
  parameter int WAY_BITS       = 3,
  parameter int ID_BITS        = 4,
  parameter int FWD_STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [ID_BITS-1:0]  req_id,
  input  logic                fwd_valid,
  output logic                fwd_ready,
  input  logic [TAG_BITS-1:0] fwd_tag,
  input  logic [SET_BITS-1:0] fwd_set,
  input  logic [ID_BITS-1:0]  fwd_id,
  output logic                rd_en,
  output logic [SET_BITS-1:0] rd_set,
  output logic                lookup_en,
  output logic                lookup_mode,
  output logic [TAG_BITS-1:0] lookup_tag,
  input  logic                tag_hit_next,
  input  logic [WAY_BITS-1:0] way_hit_next,
  input  logic                empty_way_found_next,
  input  logic [WAY_BITS-1:0] empty_way_next,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_is_fwd,
  output logic [ID_BITS-1:0]  resp_id,
  output logic [SET_BITS-1:0] resp_set,
  output logic                resp_tag_hit,
  output logic [WAY_BITS-1:0] resp_way,
  output logic                resp_empty_found,
  output logic [WAY_BITS-1:0] resp_empty_way,
  output logic                busy
);

  localparam int CNT_W = $clog2(FWD_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(FWD_STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_SET = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q,   state_d;
  logic [CNT_W-1:0]    starve_q,  starve_d;
  logic [TAG_BITS-1:0] cap_tag_q, cap_tag_d;
  logic [SET_BITS-1:0] cap_set_q, cap_set_d;
  logic [ID_BITS-1:0]  cap_id_q,  cap_id_d;
  logic                cap_fwd_q, cap_fwd_d;
  logic                rsp_hit_q, rsp_hit_d;
  logic [WAY_BITS-1:0] rsp_way_q, rsp_way_d;
  logic                rsp_ef_q,  rsp_ef_d;
  logic [WAY_BITS-1:0] rsp_ew_q,  rsp_ew_d;

  logic arb_en_s;
  logic fwd_win_s;
  logic req_win_s;
  logic accept_s;

  // Arbitration window and winner selection.
  always_comb begin
    arb_en_s = 1'b0;
    if (state_q == ST_IDLE) begin
      arb_en_s = 1'b1;
    end else begin
`ifdef L2_LKP_PIPE_EN
      arb_en_s = (state_q == ST_RESP) && resp_ready;
`else
      arb_en_s = 1'b0;
`endif
    end
    // A waiting request blocks forwards only once it has been starved.
    fwd_win_s = arb_en_s && fwd_valid && !(req_valid && (starve_q == STARVE_MAX));
    req_win_s = arb_en_s && req_valid && !fwd_win_s;
    accept_s  = fwd_win_s || req_win_s;
  end

  // Next-state, capture and starvation-counter logic.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    cap_tag_d = cap_tag_q;
    cap_set_d = cap_set_q;
    cap_id_d  = cap_id_q;
    cap_fwd_d = cap_fwd_q;
    rsp_hit_d = rsp_hit_q;
    rsp_way_d = rsp_way_q;
    rsp_ef_d  = rsp_ef_q;
    rsp_ew_d  = rsp_ew_q;

    if (arb_en_s) begin
      if (req_win_s || !req_valid) begin
        starve_d = '0;
      end else if (fwd_win_s && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + CNT_ONE;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end

    if (fwd_win_s) begin
      cap_tag_d = fwd_tag;
      cap_set_d = fwd_set;
      cap_id_d  = fwd_id;
      cap_fwd_d = 1'b1;
    end else if (req_win_s) begin
      cap_tag_d = req_tag;
      cap_set_d = req_set;
      cap_id_d  = req_id;
      cap_fwd_d = 1'b0;
    end else begin
      cap_fwd_d = cap_fwd_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_RD_SET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_SET: begin
        state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        rsp_hit_d = tag_hit_next;
        rsp_way_d = way_hit_next;
        // Forwards never allocate, so the empty-way result is meaningless.
        rsp_ef_d  = cap_fwd_q ? 1'b0 : empty_way_found_next;
        rsp_ew_d  = cap_fwd_q ? '0   : empty_way_next;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = accept_s ? ST_RD_SET : ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      cap_tag_q <= '0;
      cap_set_q <= '0;
      cap_id_q  <= '0;
      cap_fwd_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_way_q <= '0;
      rsp_ef_q  <= 1'b0;
      rsp_ew_q  <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      cap_tag_q <= cap_tag_d;
      cap_set_q <= cap_set_d;
      cap_id_q  <= cap_id_d;
      cap_fwd_q <= cap_fwd_d;
      rsp_hit_q <= rsp_hit_d;
      rsp_way_q <= rsp_way_d;
      rsp_ef_q  <= rsp_ef_d;
      rsp_ew_q  <= rsp_ew_d;
    end
  end

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign req_ready = req_win_s && !rst;
  assign fwd_ready = fwd_win_s && !rst;

  assign rd_en       = (state_q == ST_RD_SET);
  assign rd_set      = rd_en ? cap_set_q : '0;
  assign lookup_en   = (state_q == ST_LOOKUP);
  assign lookup_mode = lookup_en && cap_fwd_q;
  assign lookup_tag  = lookup_en ? cap_tag_q : '0;

  assign resp_valid       = (state_q == ST_RESP);
  assign resp_is_fwd      = cap_fwd_q;
  assign resp_id          = cap_id_q;
  assign resp_set         = cap_set_q;
  assign resp_tag_hit     = rsp_hit_q;
  assign resp_way         = rsp_way_q;
  assign resp_empty_found = rsp_ef_q;
  assign resp_empty_way   = rsp_ew_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_l2_lookup_sched.sv
// ---------------------------------------------------------------------------
// tb_l2_lookup_sched
//
// Directed self-checking bench for l2_lookup_sched. Inputs change and outputs
// are sampled around the falling clock edge; the design acts on rising edges.
// Expected values are hand-computed constants. When L2_LKP_PIPE_EN is
// defined the throughput expectations switch to the pipelined behaviour.
// ---------------------------------------------------------------------------
module tb_l2_lookup_sched;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready;
  logic [14:0] req_tag;
  logic [8:0]  req_set;
  logic [3:0]  req_id;
  logic        fwd_valid, fwd_ready;
  logic [14:0] fwd_tag;
  logic [8:0]  fwd_set;
  logic [3:0]  fwd_id;
  logic        rd_en;
  logic [8:0]  rd_set;
  logic        lookup_en, lookup_mode;
  logic [14:0] lookup_tag;
  logic        tag_hit_next;
  logic [2:0]  way_hit_next;
  logic        empty_way_found_next;
  logic [2:0]  empty_way_next;
  logic        resp_valid, resp_ready, resp_is_fwd;
  logic [3:0]  resp_id;
  logic [8:0]  resp_set;
  logic        resp_tag_hit;
  logic [2:0]  resp_way;
  logic        resp_empty_found;
  logic [2:0]  resp_empty_way;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef L2_LKP_PIPE_EN
  localparam int  EXP_SPACING = 3;
  localparam logic EXP_PIPE   = 1'b1;
`else
  localparam int  EXP_SPACING = 4;
  localparam logic EXP_PIPE   = 1'b0;
`endif

  l2_lookup_sched dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_tag              (req_tag),
    .req_set              (req_set),
    .req_id               (req_id),
    .fwd_valid            (fwd_valid),
    .fwd_ready            (fwd_ready),
    .fwd_tag              (fwd_tag),
    .fwd_set              (fwd_set),
    .fwd_id               (fwd_id),
    .rd_en                (rd_en),
    .rd_set               (rd_set),
    .lookup_en            (lookup_en),
    .lookup_mode          (lookup_mode),
    .lookup_tag           (lookup_tag),
    .tag_hit_next         (tag_hit_next),
    .way_hit_next         (way_hit_next),
    .empty_way_found_next (empty_way_found_next),
    .empty_way_next       (empty_way_next),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_is_fwd          (resp_is_fwd),
    .resp_id              (resp_id),
    .resp_set             (resp_set),
    .resp_tag_hit         (resp_tag_hit),
    .resp_way             (resp_way),
    .resp_empty_found     (resp_empty_found),
    .resp_empty_way       (resp_empty_way),
    .busy                 (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it differs.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One complete transaction from IDLE with latency and result checks.
  // stall = number of RESP cycles held with resp_ready = 0 (both valids high).
  task automatic txn(input bit fwd, input bit both, input logic [14:0] tag,
                     input logic [8:0] set, input logic [3:0] id,
                     input bit hit, input logic [2:0] way,
                     input bit ef, input logic [2:0] ew, input int stall);
    logic exp_ef;
    logic [2:0] exp_ew;
    exp_ef = fwd ? 1'b0 : ef;
    exp_ew = fwd ? 3'd0 : ew;
    // Cycle T: present the transaction.
    @(negedge clk);
    resp_ready = 1'b0;
    if (fwd) begin
      fwd_valid = 1'b1; fwd_tag = tag; fwd_set = set; fwd_id = id;
      req_valid = both; req_tag = 15'h0123; req_set = 9'h0AA; req_id = 4'h9;
    end else begin
      req_valid = 1'b1; req_tag = tag; req_set = set; req_id = id;
      fwd_valid = 1'b0;
    end
    #1;
    chk("accept_req_ready", {31'd0, req_ready}, {31'd0, !fwd});
    chk("accept_fwd_ready", {31'd0, fwd_ready}, {31'd0, fwd});
    // T+1: set read.
    @(negedge clk);
    req_valid = 1'b0; fwd_valid = 1'b0;
    tag_hit_next = hit; way_hit_next = way;
    empty_way_found_next = ef; empty_way_next = ew;
    #1;
    chk("rd_en", {31'd0, rd_en}, 32'd1);
    chk("rd_set", {23'd0, rd_set}, {23'd0, set});
    chk("rd_no_lookup", {31'd0, lookup_en}, 32'd0);
    // T+2: lookup.
    @(negedge clk);
    #1;
    chk("lookup_en", {31'd0, lookup_en}, 32'd1);
    chk("lookup_mode", {31'd0, lookup_mode}, {31'd0, fwd});
    chk("lookup_tag", {17'd0, lookup_tag}, {17'd0, tag});
    chk("lookup_no_rd", {31'd0, rd_en}, 32'd0);
    // T+3 onward: response, optionally stalled.
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      tag_hit_next = ~hit; way_hit_next = ~way;
      empty_way_found_next = ~ef; empty_way_next = ~ew;
      if (i < stall) begin
        req_valid = 1'b1; fwd_valid = 1'b1; resp_ready = 1'b0;
      end else begin
        req_valid = 1'b0; fwd_valid = 1'b0; resp_ready = 1'b1;
      end
      #1;
      chk("resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("resp_is_fwd", {31'd0, resp_is_fwd}, {31'd0, fwd});
      chk("resp_id", {28'd0, resp_id}, {28'd0, id});
      chk("resp_set", {23'd0, resp_set}, {23'd0, set});
      chk("resp_tag_hit", {31'd0, resp_tag_hit}, {31'd0, hit});
      chk("resp_way", {29'd0, resp_way}, {29'd0, way});
      chk("resp_empty_found", {31'd0, resp_empty_found}, {31'd0, exp_ef});
      chk("resp_empty_way", {29'd0, resp_empty_way}, {29'd0, exp_ew});
      if (i < stall) begin
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        chk("stall_fwd_ready", {31'd0, fwd_ready}, 32'd0);
        chk("stall_rd_en", {31'd0, rd_en}, 32'd0);
      end
    end
    @(negedge clk);
    #1;
    chk("back_to_idle", {31'd0, busy}, 32'd0);
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
  endtask

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    bit       grants[$];
    int       rd_t[$];
    bit       both_seen;
    bit       pipe_seen;
    int       cyc;

    rst = 1'b1;
    req_valid = 1'b1; req_tag = '0; req_set = '0; req_id = '0;
    fwd_valid = 1'b0; fwd_tag = '0; fwd_set = '0; fwd_id = '0;
    tag_hit_next = 1'b0; way_hit_next = '0;
    empty_way_found_next = 1'b0; empty_way_next = '0;
    resp_ready = 1'b0;

    // Reset state.
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_id", {28'd0, resp_id}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single request: hit on way 6.
    txn(1'b0, 1'b0, 15'h01A2, 9'h005, 4'd3, 1'b1, 3'd6, 1'b1, 3'd2, 0);

    // Simultaneous request and forward: forward wins, empty fields zeroed.
    txn(1'b1, 1'b1, 15'h7FFF, 9'h1FF, 4'hA, 1'b0, 3'd1, 1'b1, 3'd5, 0);

    // Response backpressure for 5 cycles.
    txn(1'b0, 1'b0, 15'h0456, 9'h100, 4'h7, 1'b1, 3'd3, 1'b1, 3'd4, 5);

    // Starvation: both valid held -> 4 forwards, 1 request, then forward.
    both_seen = 1'b0;
    for (int i = 0; i < 60 && grants.size() < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b1; fwd_valid = 1'b1; resp_ready = 1'b1;
      #1;
      if (req_ready && fwd_ready) both_seen = 1'b1;
      if (fwd_ready) grants.push_back(1'b1);
      else if (req_ready) grants.push_back(1'b0);
    end
    chk("starve_grant_count", grants.size(), 32'd6);
    chk("starve_never_both", {31'd0, both_seen}, 32'd0);
    if (grants.size() == 6) begin
      chk("starve_g0", {31'd0, grants[0]}, 32'd1);
      chk("starve_g1", {31'd0, grants[1]}, 32'd1);
      chk("starve_g2", {31'd0, grants[2]}, 32'd1);
      chk("starve_g3", {31'd0, grants[3]}, 32'd1);
      chk("starve_g4_req", {31'd0, grants[4]}, 32'd0);
      chk("starve_g5_fwd", {31'd0, grants[5]}, 32'd1);
    end
    @(negedge clk);
    req_valid = 1'b0; fwd_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    #1;
    chk("starve_drain_idle", {31'd0, busy}, 32'd0);

    // Reset pulse during LOOKUP drops the transaction.
    @(negedge clk);
    req_valid = 1'b1; req_tag = 15'h0777; req_set = 9'h033; req_id = 4'h5;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_lookup_en", {31'd0, lookup_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_lookup_en", {31'd0, lookup_en}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_lookup_tag", {17'd0, lookup_tag}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("dropped_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    txn(1'b0, 1'b0, 15'h2345, 9'h0C8, 4'hE, 1'b1, 3'd7, 1'b0, 3'd0, 0);

    // Throughput with back-to-back requests and resp_ready held high.
    pipe_seen = 1'b0;
    for (cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      req_valid = 1'b1; req_tag = 15'h0042; req_set = 9'h011; req_id = 4'h1;
      resp_ready = 1'b1;
      #1;
      if (rd_en) rd_t.push_back(cyc);
      if (req_ready && resp_valid) pipe_seen = 1'b1;
    end
    chk("tput_rd_count_ge3", {31'd0, rd_t.size() >= 3}, 32'd1);
    if (rd_t.size() >= 3) begin
      chk("tput_spacing_a", rd_t[1] - rd_t[0], EXP_SPACING);
      chk("tput_spacing_b", rd_t[2] - rd_t[1], EXP_SPACING);
    end
    chk("tput_ready_in_resp", {31'd0, pipe_seen}, {31'd0, EXP_PIPE});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    #1;
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
